// File: rtl/pipelined_data_memory.sv
// Synchronous MEM-stage data memory: valid/ready requests, byte-enable writes,
// RD_LAT-deep response pipeline, alignment/range errors, post-reset clear sweep.
module pipelined_data_memory #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              clr_we_c;
  logic              ready_q, busy_q;

  logic              accept_c;
  logic [IDX_W-1:0]  widx_c;
  logic              err_c;

  logic [RD_LAT-1:0] pipe_valid_q;
  logic [RD_LAT-1:0] pipe_err_q;
  logic [DATA_W-1:0] pipe_data_q [RD_LAT];

  // Request decode: word index plus misalignment / out-of-range detection
  always_comb begin
    accept_c = req_valid && ready_q;
    widx_c   = req_addr[OFF +: IDX_W];
    err_c    = (|req_addr[OFF-1:0]) || (64'(req_addr) >= LIMIT);
  end

  // State register, sweep index and registered ready/busy flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= (state_d == ST_READY);
      busy_q    <= (state_d == ST_CLEAR);
    end
  end

  // Next-state: sweep one word per cycle, then settle in READY until reset
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we_c  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Storage array: sweep writes zero, accepted error-free writes merge by byte lane
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_idx_q] <= '0;
    end else if (accept_c && req_we && !err_c) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (req_be[b]) mem[widx_c][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // Response pipeline: read data captured at accept edge, then delayed RD_LAT-1 stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= accept_c;
      pipe_err_q[0]   <= accept_c && err_c;
      pipe_data_q[0]  <= (accept_c && !req_we && !err_c) ? mem[widx_c] : '0;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign resp_valid = pipe_valid_q[RD_LAT-1];
  assign resp_err   = pipe_err_q[RD_LAT-1];
  assign resp_rdata = pipe_data_q[RD_LAT-1];

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Directed bench: instance a (RD_LAT=1, clear sweep), instance b (RD_LAT=3, no sweep).
module tb_pipelined_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        a_rst_n, a_valid, a_ready, a_we, a_resp_valid, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;

  logic        b_rst_n, b_valid, b_ready, b_we, b_resp_valid, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  pipelined_data_memory #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_err(a_err), .busy(a_busy)
  );

  pipelined_data_memory #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(32), .RD_LAT(3), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_err(b_err), .busy(b_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
  endtask

  task automatic b_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = 4'hF;
  endtask

  task automatic test_reset;
    a_rst_n = 1'b0;
    a_valid = 1'b0;
    step; step;
    n_cmp++;
    if ({a_ready, a_busy, a_resp_valid, a_err, a_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b busy=%b v=%b e=%b d=%h, want rdy=0 busy=1 v=0 e=0 d=0",
               a_ready, a_busy, a_resp_valid, a_err, a_rdata);
    end
    a_rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step;
      n_cmp++;
      if ({a_busy, a_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL sweep_busy cycle %0d: busy=%b rdy=%b, want busy=1 rdy=0", i, a_busy, a_ready);
      end
    end
    step;
    n_cmp++;
    if ({a_busy, a_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL sweep_done: busy=%b rdy=%b, want busy=0 rdy=1", a_busy, a_ready);
    end
  endtask

  task automatic test_byte_enable;
    a_req(1'b1, 32'h08, 32'hAABBCCDD, 4'b1111);
    step;
    n_cmp++;
    if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL be_write1_resp: v=%b e=%b d=%h, want v=1 e=0 d=0", a_resp_valid, a_err, a_rdata);
    end
    a_req(1'b1, 32'h08, 32'h11223344, 4'b0101);
    step;
    n_cmp++;
    if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL be_write2_resp: v=%b e=%b d=%h, want v=1 e=0 d=0", a_resp_valid, a_err, a_rdata);
    end
    a_req(1'b1, 32'h08, 32'hFFFFFFFF, 4'b0000);
    step;
    n_cmp++;
    if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL be_zero_resp: v=%b e=%b d=%h, want v=1 e=0 d=0", a_resp_valid, a_err, a_rdata);
    end
    a_req(1'b0, 32'h08, 32'h0, 4'h0);
    step;
    n_cmp++;
    if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, 32'hAA22CC44}) begin
      n_fail++;
      $display("FAIL be_read: v=%b e=%b d=%h, want v=1 e=0 d=aa22cc44", a_resp_valid, a_err, a_rdata);
    end
    a_valid = 1'b0;
    step;
    n_cmp++;
    if ({a_resp_valid, a_err, a_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL idle_resp: v=%b e=%b d=%h, want v=0 e=0 d=0", a_resp_valid, a_err, a_rdata);
    end
  endtask

  task automatic test_errors;
    logic [31:0] addr_t [6] = '{32'h04, 32'h06, 32'h80, 32'h05, 32'h04, 32'h00};
    logic        we_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] wd_t   [6] = '{32'h12345678, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic        err_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] rd_t   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0};
    for (int i = 0; i < 6; i++) begin
      a_req(we_t[i], addr_t[i], wd_t[i], 4'hF);
      step;
      n_cmp++;
      if ({a_resp_valid, a_err, a_rdata} !== {1'b1, err_t[i], rd_t[i]}) begin
        n_fail++;
        $display("FAIL err_seq[%0d] addr=%h: v=%b e=%b d=%h, want v=1 e=%b d=%h",
                 i, addr_t[i], a_resp_valid, a_err, a_rdata, err_t[i], rd_t[i]);
      end
    end
    a_valid = 1'b0;
    step;
  endtask

  task automatic test_raw_hazard;
    logic        we_t [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] wd_t [5] = '{32'h5, 32'h0, 32'h0, 32'h9, 32'h0};
    logic [31:0] rd_t [5] = '{32'h0, 32'h5, 32'h5, 32'h0, 32'h9};
    for (int i = 0; i < 5; i++) begin
      a_req(we_t[i], 32'h10, wd_t[i], 4'hF);
      step;
      n_cmp++;
      if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, rd_t[i]}) begin
        n_fail++;
        $display("FAIL raw_seq[%0d]: v=%b e=%b d=%h, want v=1 e=0 d=%h",
                 i, a_resp_valid, a_err, a_rdata, rd_t[i]);
      end
    end
    a_valid = 1'b0;
    step;
  endtask

  task automatic test_midsweep_reset;
    a_rst_n = 1'b0;
    step;
    a_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step;
    a_req(1'b1, 32'h0C, 32'hDEADBEEF, 4'hF);
    a_rst_n = 1'b0;
    step;
    n_cmp++;
    if ({a_busy, a_ready, a_resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midsweep_in_reset: busy=%b rdy=%b v=%b, want busy=1 rdy=0 v=0",
               a_busy, a_ready, a_resp_valid);
    end
    a_rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      step;
      n_cmp++;
      if ({a_busy, a_ready, a_resp_valid} !== 3'b100) begin
        n_fail++;
        $display("FAIL resweep cycle %0d: busy=%b rdy=%b v=%b, want busy=1 rdy=0 v=0",
                 i, a_busy, a_ready, a_resp_valid);
      end
    end
    step;
    n_cmp++;
    if ({a_busy, a_ready, a_resp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL resweep_done: busy=%b rdy=%b v=%b, want busy=0 rdy=1 v=0",
               a_busy, a_ready, a_resp_valid);
    end
    for (int i = 0; i < 32; i++) begin
      a_req(1'b0, 32'(i * 4), 32'h0, 4'h0);
      step;
      n_cmp++;
      if ({a_resp_valid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL clear_readback addr=%h: v=%b e=%b d=%h, want v=1 e=0 d=0",
                 i * 4, a_resp_valid, a_err, a_rdata);
      end
    end
    a_valid = 1'b0;
    step;
  endtask

  task automatic test_noclear_reset;
    b_rst_n = 1'b0;
    b_valid = 1'b0;
    step; step;
    n_cmp++;
    if ({b_ready, b_busy, b_resp_valid, b_err, b_rdata} !== {1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL b_reset_values: rdy=%b busy=%b v=%b e=%b d=%h, want all 0",
               b_ready, b_busy, b_resp_valid, b_err, b_rdata);
    end
    b_rst_n = 1'b1;
    step;
    n_cmp++;
    if ({b_ready, b_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b_ready_after_reset: rdy=%b busy=%b, want rdy=1 busy=0", b_ready, b_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic        we_t [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_t [10] = '{32'h00, 32'h04, 32'h08, 32'h00, 32'h04, 32'h08,
                               32'h0C, 32'h0C, 32'h0C, 32'h0C};
    logic [31:0] wd_t [10] = '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0, 32'h0,
                               32'hA, 32'h0, 32'hB, 32'h0};
    logic [31:0] rd_t [10] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h104, 32'h108,
                               32'h0, 32'hA, 32'h0, 32'hB};
    for (int s = 0; s < 14; s++) begin
      if (s < 10) b_req(we_t[s], ad_t[s], wd_t[s]);
      else        b_valid = 1'b0;
      step;
      if (s >= 2 && s < 12) begin
        n_cmp++;
        if ({b_busy, b_resp_valid, b_err, b_rdata} !== {1'b0, 1'b1, 1'b0, rd_t[s-2]}) begin
          n_fail++;
          $display("FAIL lat3_resp[%0d]: busy=%b v=%b e=%b d=%h, want busy=0 v=1 e=0 d=%h",
                   s - 2, b_busy, b_resp_valid, b_err, b_rdata, rd_t[s-2]);
        end
      end else begin
        n_cmp++;
        if ({b_busy, b_resp_valid, b_rdata} !== {1'b0, 1'b0, 32'h0}) begin
          n_fail++;
          $display("FAIL lat3_quiet step %0d: busy=%b v=%b d=%h, want busy=0 v=0 d=0",
                   s, b_busy, b_resp_valid, b_rdata);
        end
      end
    end
  endtask

  task automatic test_retain_reset;
    logic [31:0] rd_t [5] = '{32'h0, 32'h0, 32'h104, 32'hB, 32'h0};
    logic        v_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    b_req(1'b0, 32'h04, 32'h0);
    step;
    b_valid = 1'b0;
    b_rst_n = 1'b0;
    step; step; step;
    n_cmp++;
    if ({b_resp_valid, b_busy, b_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL b_flush: v=%b busy=%b rdy=%b, want all 0", b_resp_valid, b_busy, b_ready);
    end
    b_rst_n = 1'b1;
    step;
    n_cmp++;
    if ({b_ready, b_busy, b_resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL b_ready_again: rdy=%b busy=%b v=%b, want rdy=1 busy=0 v=0",
               b_ready, b_busy, b_resp_valid);
    end
    for (int s = 0; s < 5; s++) begin
      if (s == 0)      b_req(1'b0, 32'h04, 32'h0);
      else if (s == 1) b_req(1'b0, 32'h0C, 32'h0);
      else             b_valid = 1'b0;
      step;
      n_cmp++;
      if ({b_busy, b_resp_valid, b_err, b_rdata} !== {1'b0, v_t[s], 1'b0, rd_t[s]}) begin
        n_fail++;
        $display("FAIL retain step %0d: busy=%b v=%b e=%b d=%h, want busy=0 v=%b e=0 d=%h",
                 s, b_busy, b_resp_valid, b_err, b_rdata, v_t[s], rd_t[s]);
      end
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    #2;
    test_reset;
    test_byte_enable;
    test_errors;
    test_raw_hazard;
    test_midsweep_reset;
    test_noclear_reset;
    test_back_to_back;
    test_retain_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
